// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD countdown timer.
// The master drives the controls and the slave (the timer) drives the count and flags.
interface bcd_down_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  busy;
  logic                  done;
  logic                  expired;

  modport master (
    output load, load_val, start, pause, tick,
    input  count, busy, done, expired
  );

  modport slave (
    input  load, load_val, start, pause, tick,
    output count, busy, done, expired
  );
endinterface

// File: rtl/bcd_down_timer.sv
// Cascadable BCD countdown timer: loads a clamped BCD preset and decrements once
// per tick in RUN, with a rippling borrow chain and expiry on reaching zero.

module bcd_down_digit (
  input  logic [3:0] cur,
  input  logic       bin,
  input  logic [3:0] ld,
  output logic [3:0] dec,
  output logic       bout,
  output logic [3:0] ld_san
);
  always_comb begin
    bout   = bin && (cur == 4'd0);
    dec    = cur;
    if (bin) dec = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    ld_san = (ld > 4'd9) ? 4'd9 : ld;
  end
endmodule

module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_down_timer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  cnt_q, cnt_d;
  logic                    done_q, done_d;

  logic [DIGITS-1:0][3:0]  ld_raw, ld_san, dec_val;
  logic [DIGITS:0]         borrow;
  logic                    cnt_zero, dec_zero;

  assign ld_raw    = bus.load_val;
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_down_digit u_dig (
      .cur    (cnt_q[g]),
      .bin    (borrow[g]),
      .ld     (ld_raw[g]),
      .dec    (dec_val[g]),
      .bout   (borrow[g+1]),
      .ld_san (ld_san[g])
    );
  end

  // A borrow out of the top digit means the count was already zero.
  assign cnt_zero = borrow[DIGITS];
  assign dec_zero = (dec_val == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (bus.load) begin
      cnt_d   = ld_san;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (!bus.pause && bus.start) begin
          if (cnt_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        RUN: if (bus.pause) begin
          state_d = PAUSED;
        end else if (bus.tick && !cnt_zero) begin
          cnt_d = dec_val;
          if (dec_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        PAUSED: if (!bus.pause && bus.start) state_d = RUN;
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.count   = cnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == RUN) || (state_q == PAUSED);
  assign bus.expired = (state_q == DONE);
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed-vector bench for bcd_down_timer with hand-computed expected values.
module tb_bcd_down_timer;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bcd_down_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load_val = v;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic b, input logic d, input logic e);
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, bus.done}, {31'd0, d});
    chk({tag, ".expired"}, {31'd0, bus.expired}, {31'd0, e});
  endtask

  logic [15:0] seq12 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                              16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
  logic [15:0] seq3 [3] = '{16'h0002, 16'h0001, 16'h0000};

  initial begin
    bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    // Reset
    step();
    rst = 1'b0;
    chk("rst.count", {16'd0, bus.count}, 32'h0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);

    // 1: basic countdown from 12
    do_load(16'h0012);
    chk("t1.load", {16'd0, bus.count}, 32'h0012);
    chk("t1.busy0", {31'd0, bus.busy}, 32'd0);
    bus.tick = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t1.start_tick_nodec", {16'd0, bus.count}, 32'h0012);
    chk("t1.busy1", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t1.cnt%0d", i), {16'd0, bus.count}, {16'd0, seq12[i]});
      chk($sformatf("t1.done%0d", i), {31'd0, bus.done}, (i == 11) ? 32'd1 : 32'd0);
    end
    chk_flags("t1.expire", 1'b0, 1'b1, 1'b1);
    step();
    bus.tick = 1'b0;
    chk("t1.after.count", {16'd0, bus.count}, 32'h0);
    chk_flags("t1.after", 1'b0, 1'b0, 1'b1);

    // 2: borrow chain
    do_load(16'h1000); do_start(); do_tick();
    chk("t2.borrow3", {16'd0, bus.count}, 32'h0999);
    do_load(16'h0100); do_start(); do_tick();
    chk("t2.borrow2", {16'd0, bus.count}, 32'h0099);

    // 3: pause / resume
    do_load(16'h0005); do_start(); do_tick(); do_tick();
    chk("t3.run", {16'd0, bus.count}, 32'h0003);
    bus.pause = 1'b1; bus.tick = 1'b1;
    step();
    chk("t3.pause_tick", {16'd0, bus.count}, 32'h0003);
    chk("t3.pause_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.pause = 1'b0;
    step();
    chk("t3.start_pause_held", {16'd0, bus.count}, 32'h0003);
    bus.tick = 1'b0;
    do_start();
    bus.tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3.cnt%0d", i), {16'd0, bus.count}, {16'd0, seq3[i]});
      chk($sformatf("t3.done%0d", i), {31'd0, bus.done}, (i == 2) ? 32'd1 : 32'd0);
    end
    bus.tick = 1'b0;

    // 4: edge loads
    do_load(16'h0000); do_start();
    chk("t4.zero.count", {16'd0, bus.count}, 32'h0);
    chk_flags("t4.zero", 1'b0, 1'b1, 1'b1);
    step();
    chk("t4.zero.done_once", {31'd0, bus.done}, 32'd0);
    do_load(16'h0A3F);
    chk("t4.sanitize", {16'd0, bus.count}, 32'h0939);
    chk("t4.sanitize.exp", {31'd0, bus.expired}, 32'd0);

    // 5: load beats tick in RUN, then reset mid-count
    do_load(16'h0042); do_start();
    bus.load_val = 16'h0100; bus.load = 1'b1; bus.tick = 1'b1;
    step();
    bus.load = 1'b0; bus.tick = 1'b0;
    chk("t5.load_prio", {16'd0, bus.count}, 32'h0100);
    chk("t5.idle_busy", {31'd0, bus.busy}, 32'd0);
    do_start(); do_tick();
    chk("t5.run", {16'd0, bus.count}, 32'h0099);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.rst.count", {16'd0, bus.count}, 32'h0);
    chk_flags("t5.rst", 1'b0, 1'b0, 1'b0);

    // 6: DONE lock
    do_load(16'h0001); do_start(); do_tick();
    chk_flags("t6.expire", 1'b0, 1'b1, 1'b1);
    bus.tick = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t6.lock.cnt%0d", i), {16'd0, bus.count}, 32'h0);
      chk_flags($sformatf("t6.lock%0d", i), 1'b0, 1'b0, 1'b1);
    end
    bus.tick = 1'b0; bus.start = 1'b0;
    do_load(16'h0003);
    chk("t6.reload.count", {16'd0, bus.count}, 32'h0003);
    chk_flags("t6.reload", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Cascadable multi-digit BCD countdown timer. It is the down-counting counterpart of the team's decade up-counter.
- Loads a BCD preset and decrements once per enabled tick, borrowing across digits.
- Signals expiry when the count reaches zero.
- Used as the countdown/timeout element beside the up-counting display counters; its count drives the same BCD display path.

Parameters:
- DIGITS, 4, number of BCD digits (1..8). Digit 0 is least significant, at count[3:0].

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  load preset (priority over all other controls except rst)
- load_val  input  4*DIGITS  BCD preset value
- start  input  1  start/resume counting
- pause  input  1  freeze counting
- tick  input  1  count enable; one decrement per cycle when high in RUN
- count  output  4*DIGITS  current BCD value (registered)
- busy  output  1  high in RUN or PAUSED
- done  output  1  one-cycle pulse when count reaches zero
- expired  output  1  level, high while in DONE

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high. Nothing is sampled asynchronously.
- Reset (rst=1 at a clk edge): state=IDLE, count=0, busy=0, done=0, expired=0. rst overrides every other input.
- States and transitions (priority rst > load > pause > start > tick):
  - IDLE:
    - load: count<=load_val (sanitized), stay IDLE.
    - start with count!=0: go RUN.
    - start with count==0: go DONE and pulse done.
  - RUN:
    - load: go IDLE with the new value.
    - pause: go PAUSED.
    - tick: decrement.
    - start alone: no effect.
  - PAUSED:
    - load: go IDLE.
    - start (pause low): go RUN.
    - start and pause both high: stay PAUSED (pause wins).
    - tick: ignored.
  - DONE:
    - load: go IDLE.
    - start, pause and tick: ignored.
- Sanitizing: any load_val digit >9 is stored as 9. No other digit value is ever stored.
- Decrement (RUN, tick=1, no load/pause):
  - Digit 0 decrements by 1.
  - A digit equal to 0 becomes 9 and borrows from the next digit.
  - Borrow ripples combinationally within the same cycle. The count update is registered with 1-cycle latency.
- Expiry:
  - The tick that makes count==0 moves state to DONE on the same edge.
  - done=1 for exactly that one cycle; expired=1 from that cycle onward; busy=0.
  - Count never wraps below 0; from DONE no further decrement occurs.
- Simultaneous events:
  - start and tick in the same IDLE cycle: tick is not applied; the first decrement occurs on the next tick.
  - pause and tick in the same RUN cycle: no decrement.
  - load and tick in the same cycle: count=load_val; no decrement.
- done is a pulse on entering DONE only. It is never re-asserted while remaining in DONE.
- Reset mid-count (any state): next cycle count=0, state IDLE, all flags 0.

Test Plan:
1. rst=1 one cycle, then load_val=16'h0012, load=1 -> count=16'h0012, busy=0; start=1 -> busy=1; 12 ticks -> count steps 0011,0010,0009,...,0000. done=1 for exactly the cycle count reaches 0000; expired=1 thereafter, busy=0.
2. Borrow chain: load 16'h1000, start, 1 tick -> count=16'h0999. Load 16'h0100, start, 1 tick -> 16'h0099.
3. Pause/resume: load 16'h0005, start, 2 ticks -> 0003. pause=1 with tick=1 -> stays 0003, busy=1. start=1 and pause=1 together -> still PAUSED. start alone, then 3 ticks -> 0000 with a done pulse.
4. Edge loads:
   - load 16'h0000, start -> immediate DONE, done pulse one cycle, count stays 0000.
   - load 16'h0A3F -> count=16'h0939.
5. Priority and reset:
   - In RUN at 16'h0042: load=1 and tick=1 with load_val=16'h0100 -> count=16'h0100, state IDLE, busy=0.
   - Then start, 1 tick, then rst=1 -> count=0000, busy/done/expired=0 on the next cycle.
6. DONE lock: after expiry, 5 ticks plus start -> count stays 0000, expired=1, done stays 0. A load then returns to IDLE with expired=0.
